// File: rtl/alu_arbiter_if.sv
// Requester, ALU and result-consumer signals of the shared-ALU arbiter.
// slave: arbiter side; master: requesters, ALU and consumer side.
interface alu_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             req0;
  logic             req1;
  logic             mode0;
  logic             mode1;
  logic [2:0]       opcode0;
  logic [2:0]       opcode1;
  logic [WIDTH-1:0] a0;
  logic [WIDTH-1:0] b0;
  logic [WIDTH-1:0] a1;
  logic [WIDTH-1:0] b1;
  logic             gnt0;
  logic             gnt1;
  logic             alu_mode;
  logic [2:0]       alu_opcode;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic             alu_execute;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             result_id;
  logic             result_err;
  logic             result_ack;
  logic [CNT_W-1:0] op_count;

  modport slave (
    input  req0, req1, mode0, mode1,
    input  opcode0, opcode1, a0, b0, a1, b1,
    input  alu_result, result_ack,
    output gnt0, gnt1,
    output alu_mode, alu_opcode, alu_a, alu_b,
    output alu_execute,
    output result, result_valid,
    output result_id, result_err, op_count
  );

  modport master (
    output req0, req1, mode0, mode1,
    output opcode0, opcode1, a0, b0, a1, b1,
    output alu_result, result_ack,
    input  gnt0, gnt1,
    input  alu_mode, alu_opcode, alu_a, alu_b,
    input  alu_execute,
    input  result, result_valid,
    input  result_id, result_err, op_count
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters,
// with a registered, tagged result held until acknowledged.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic         clock_pulse,
  input  logic         resetn,
  alu_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_INC = 3'b011;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [1:0]       state_q, state_d;
  logic             last_id_q, last_id_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             alu_mode_q, alu_mode_d;
  logic [2:0]       alu_opcode_q, alu_opcode_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             result_id_q, result_id_d;
  logic             result_err_q, result_err_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;

  logic pick1;
  logic legal;
  logic st_idle, st_exec, st_done;

  assign st_idle = (state_q == IDLE);
  assign st_exec = (state_q == EXEC);
  assign st_done = (state_q == DONE);

  // Tie goes to the port that did not win last time.
  assign pick1 = bus.req1 & (~bus.req0 | ~last_id_q);
  assign legal = (alu_opcode_q == OP_ADD) |
                 (alu_opcode_q == OP_INC);

  always_comb begin
    state_d        = state_q;
    last_id_d      = last_id_q;
    gnt0_d         = gnt0_q;
    gnt1_d         = gnt1_q;
    alu_mode_d     = alu_mode_q;
    alu_opcode_d   = alu_opcode_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    result_id_d    = result_id_q;
    result_err_d   = result_err_q;
    op_count_d     = op_count_q;
    unique case (1'b1)
      st_idle: begin
        if (bus.req0 | bus.req1) begin
          state_d      = EXEC;
          gnt0_d       = ~pick1;
          gnt1_d       = pick1;
          last_id_d    = pick1;
          result_id_d  = pick1;
          alu_mode_d   = pick1 ? bus.mode1   : bus.mode0;
          alu_opcode_d = pick1 ? bus.opcode1 : bus.opcode0;
          alu_a_d      = pick1 ? bus.a1      : bus.a0;
          alu_b_d      = pick1 ? bus.b1      : bus.b0;
        end
      end
      st_exec: begin
        state_d        = DONE;
        gnt0_d         = 1'b0;
        gnt1_d         = 1'b0;
        result_d       = legal ? bus.alu_result : '0;
        result_err_d   = ~legal;
        result_valid_d = 1'b1;
      end
      st_done: begin
        if (bus.result_ack) begin
          state_d        = IDLE;
          result_valid_d = 1'b0;
          op_count_d     = op_count_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_pulse or negedge resetn) begin
    if (!resetn) begin
      state_q        <= IDLE;
      last_id_q      <= 1'b1;
      gnt0_q         <= 1'b0;
      gnt1_q         <= 1'b0;
      alu_mode_q     <= 1'b0;
      alu_opcode_q   <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      result_id_q    <= 1'b0;
      result_err_q   <= 1'b0;
      op_count_q     <= '0;
    end else begin
      state_q        <= state_d;
      last_id_q      <= last_id_d;
      gnt0_q         <= gnt0_d;
      gnt1_q         <= gnt1_d;
      alu_mode_q     <= alu_mode_d;
      alu_opcode_q   <= alu_opcode_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      result_id_q    <= result_id_d;
      result_err_q   <= result_err_d;
      op_count_q     <= op_count_d;
    end
  end

  assign bus.gnt0         = gnt0_q;
  assign bus.gnt1         = gnt1_q;
  assign bus.alu_mode     = alu_mode_q;
  assign bus.alu_opcode   = alu_opcode_q;
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.alu_execute  = st_exec & legal;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result_id    = result_id_q;
  assign bus.result_err   = result_err_q;
  assign bus.op_count     = op_count_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: requesters push expected
// results on grant, a monitor checks arbitration and results.
module tb_alu_arbiter;
  localparam int W  = 32;
  localparam int CW = 2;
  localparam logic [2:0] ADD = 3'b001;
  localparam logic [2:0] INC = 3'b011;

  typedef struct packed {
    logic         id;
    logic [W-1:0] res;
    logic         err;
  } exp_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  alu_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clock_pulse (clk),
    .resetn      (rstn),
    .bus         (bus)
  );

  // ALU model; illegal opcodes give a nonzero value that must be masked.
  assign bus.alu_result =
    (bus.alu_opcode == INC) ? bus.alu_a + 32'd1 :
    (bus.alu_opcode == ADD) ? bus.alu_a + bus.alu_b :
                              bus.alu_a | 32'd1;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic ack_hold = 1'b0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic legal(input logic [2:0] op);
    return (op == ADD) || (op == INC);
  endfunction

  function automatic logic [2:0] rand_op();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4) return ADD;
    if (r < 8) return INC;
    if (r == 8) return 3'b111;
    return 3'b000;
  endfunction

  function automatic logic [W-1:0] rand_val();
    if ($urandom_range(0, 3) == 0) return '1;
    return W'($urandom);
  endfunction

  task automatic check_zero(input string tag);
    chk({tag, "_ctrl"},
        {bus.gnt0, bus.gnt1, bus.alu_mode, bus.alu_opcode,
         bus.alu_execute, bus.result_valid, bus.result_id,
         bus.result_err, bus.op_count}, 0);
    chk({tag, "_alu_a"}, bus.alu_a, 0);
    chk({tag, "_alu_b"}, bus.alu_b, 0);
    chk({tag, "_result"}, bus.result, 0);
  endtask

  task automatic issue(input bit p, input logic m,
                       input logic [2:0] op,
                       input logic [W-1:0] a,
                       input logic [W-1:0] b);
    exp_t e;
    bit   got;
    got = 1'b0;
    @(negedge clk);
    if (!p) begin
      bus.req0 = 1'b1; bus.mode0 = m; bus.opcode0 = op;
      bus.a0 = a; bus.b0 = b;
    end else begin
      bus.req1 = 1'b1; bus.mode1 = m; bus.opcode1 = op;
      bus.a1 = a; bus.b1 = b;
    end
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (p ? bus.gnt1 : bus.gnt0) got = 1'b1;
    end
    if (!p) bus.req0 = 1'b0;
    else    bus.req1 = 1'b0;
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL grant_timeout port %0d: got no gnt want gnt", p);
    end else begin
      e.id  = p;
      e.err = !legal(op);
      if (op == ADD)      e.res = a + b;
      else if (op == INC) e.res = a + 32'd1;
      else                e.res = '0;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.result_valid) done = 1'b1;
    end
    n_cmp++;
    if (!done) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending want 0", sb.size());
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      bus.result_ack = ack_hold ? 1'b0 : ($urandom_range(0, 2) == 0);
    end
  end

  // Monitor: model sees the bus just after each rising edge.
  logic         free, last_w, pend, prev_valid;
  logic         r0, r1, g0, g1, w, ew, exp_g;
  logic [W-1:0] prev_res;
  int           cnt;
  exp_t         me;

  initial begin
    free = 1'b1; last_w = 1'b1; pend = 1'b0;
    prev_valid = 1'b0; prev_res = '0; cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (!rstn) begin
        free = 1'b1; last_w = 1'b1; pend = 1'b0;
        prev_valid = 1'b0; cnt = 0;
        sb.delete();
      end else begin
        r0 = bus.req0; r1 = bus.req1;
        g0 = bus.gnt0; g1 = bus.gnt1;
        exp_g = free && (r0 || r1);
        chk("gnt_any", g0 | g1, exp_g);
        if (pend) begin
          chk("valid_latency", bus.result_valid, 1);
          if (sb.size() == 0) begin
            chk("sb_nonempty", 0, 1);
          end else begin
            me = sb.pop_front();
            chk("result", bus.result, me.res);
            chk("result_id", bus.result_id, me.id);
            chk("result_err", bus.result_err, me.err);
          end
          pend = 1'b0;
        end else if (prev_valid && !bus.result_ack) begin
          chk("result_hold", {bus.result_valid, bus.result},
              {1'b1, prev_res});
        end
        if (prev_valid && bus.result_ack) begin
          cnt = (cnt + 1) % (1 << CW);
          chk("valid_clear", bus.result_valid, 0);
          chk("op_count", bus.op_count, cnt);
          free = 1'b1;
        end
        if (g0 | g1) begin
          w  = g1;
          ew = (r0 && r1) ? !last_w : r1;
          chk("gnt_onehot", g0 & g1, 0);
          chk("winner", w, ew);
          chk("alu_a", bus.alu_a, w ? bus.a1 : bus.a0);
          chk("alu_b", bus.alu_b, w ? bus.b1 : bus.b0);
          chk("alu_opcode", bus.alu_opcode,
              w ? bus.opcode1 : bus.opcode0);
          chk("alu_mode", bus.alu_mode, w ? bus.mode1 : bus.mode0);
          chk("alu_execute", bus.alu_execute,
              legal(w ? bus.opcode1 : bus.opcode0));
          last_w = w;
          free   = 1'b0;
          pend   = 1'b1;
        end else begin
          chk("exec_idle", bus.alu_execute, 0);
        end
        prev_valid = bus.result_valid;
        prev_res   = bus.result;
      end
    end
  end

  initial begin
    bus.req0 = 0; bus.req1 = 0; bus.mode0 = 0; bus.mode1 = 0;
    bus.opcode0 = '0; bus.opcode1 = '0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    bus.result_ack = 1'b0;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("por");
    rstn = 1'b1;

    issue(0, 1'b0, ADD, 32'd5, 32'd7);
    drain();

    fork
      begin
        issue(0, 1'b1, INC, '1, '0);
        issue(0, 1'b1, INC, '1, '0);
      end
      begin
        issue(1, 1'b0, INC, '1, '0);
        issue(1, 1'b0, INC, '1, '0);
      end
    join
    drain();

    issue(1, 1'b0, 3'b111, rand_val(), rand_val());
    drain();

    ack_hold = 1'b1;
    fork
      issue(0, 1'b0, ADD, rand_val(), rand_val());
      begin
        repeat (3) @(negedge clk);
        issue(1, 1'b1, INC, rand_val(), rand_val());
      end
      begin
        repeat (16) @(negedge clk);
        ack_hold = 1'b0;
      end
    join
    drain();

    fork
      for (int k = 0; k < 20; k++) begin
        repeat ($urandom_range(0, 4)) @(negedge clk);
        issue(0, 1'($urandom), rand_op(), rand_val(), rand_val());
      end
      for (int k = 0; k < 20; k++) begin
        repeat ($urandom_range(0, 4)) @(negedge clk);
        issue(1, 1'($urandom), rand_op(), rand_val(), rand_val());
      end
    join
    drain();

    fork
      issue(1, 1'b0, ADD, 32'd1, 32'd2);
      begin : rst_mid
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
          @(negedge clk);
          if (bus.gnt1) seen = 1'b1;
        end
        #1 rstn = 1'b0;
        #1 check_zero("mid_reset");
        repeat (2) @(negedge clk);
        rstn = 1'b1;
      end
    join

    fork
      issue(0, 1'b0, ADD, rand_val(), rand_val());
      issue(1, 1'b0, INC, rand_val(), rand_val());
    join
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
